csel_subtractor_pipe: RTL and testbench
=======================================

// Module: csel_subtractor_pipe
// PURPOSE
//   Pipelined carry-select subtractor. Computes diff = a - b - bin over WIDTH bits and reports borrow out.
//   Sits beside the carry-select adder in the arithmetic datapath as its subtract counterpart.
//   One SEG-bit segment is resolved per pipeline stage. Each segment precomputes both borrow-in cases.
//   The borrow registered by the previous stage selects the result.
//   Operands stream in and results stream out through valid/ready handshakes.
// PARAMETERS
//   WIDTH  16  operand/result width; must be a multiple of SEG
//   SEG    4   segment width; NSEG = WIDTH/SEG stages, NSEG >= 1
// PORTS
//   clk        in   1      rising-edge clock (single clock domain)
//   rst_n      in   1      asynchronous reset, active-low
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block can accept a beat this cycle
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow in
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout       out  1      borrow out (1 when unsigned a < b + bin)
//   ovf        out  1      signed overflow (present only with CSEL_OVF_FLAG_EN)
// BEHAVIOUR
//   - Arithmetic: segment k computes a_k + ~b_k + 1 for borrow-in 0 and a_k + ~b_k for borrow-in 1.
//     Segment borrow out = ~carry out. The registered borrow from stage k-1 selects (stage 0 uses bin).
//   - Skew: stage k also holds the still-unprocessed upper operand slices and the lower result slices already resolved.
//   - Latency: exactly NSEG cycles from accepted in beat to out_valid, when never stalled.
//   - Handshake: advance = !out_valid | out_ready; in_ready = advance (combinational, no skid buffer).
//     A beat is accepted when in_valid & in_ready.
//     When advance = 0, every stage holds, so diff, bout and ovf stay stable while out_valid = 1.
//     When advance = 1, all stages shift. A stage whose input is not valid becomes a bubble.
//     Bubbles are not compressed.
//   - Ordering: results leave strictly in acceptance order. No beat is dropped or duplicated.
//   - Simultaneous accept and emit in one cycle is legal, giving throughput of 1 per cycle.
//   - Reset (async assert, sync deassert handled upstream):
//     out_valid = 0, diff = 0, bout = 0, ovf = 0, all stage valids = 0.
//     Asserting reset mid-operation discards every in-flight beat.
//     in_ready = 1 during and after reset.
//   - Wrap-around: the result is modulo 2^WIDTH. For example, 0 - 1 gives all-ones with bout = 1.
// CONFIGURATION
//   CSEL_OVF_FLAG_EN defined:
//     ovf port exists and is registered with the final stage.
//     ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]); operand sign bits travel with the beat.
//   CSEL_OVF_FLAG_EN undefined:
//     ovf port and its sign-bit pipeline are absent. All other behaviour is identical.
// STRUCTURE
//   - Package csel_pkg holds constants shared with the carry-select adder:
//     default SEG, and NSEG computed as WIDTH/SEG.
//   - Sub-module csel_seg_sub (SEG-bit, combinational) contains both segment differences, both borrows,
//     and the 2:1 select on borrow-in.
//     It is instantiated NSEG times. Stage registers live in csel_subtractor_pipe.
// TESTING (WIDTH=16, SEG=4, out_ready=1 unless stated)
//   1. a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, out_valid exactly 4 cycles after accept.
//   2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; the borrow crosses all 4 segments.
//   3. a=0x0005, b=0x0003, bin=1 -> diff=0x0001, bout=0.
//      a=0x0003, b=0x0003, bin=1 -> diff=0xFFFF, bout=1.
//   4. With macro: a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1.
//      a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1.
//      a=0x0010, b=0x0001 -> ovf=0.
//   5. 8 back-to-back beats; out_ready=0 from the 2nd result for 5 cycles.
//      -> in_ready=0 while stalled; outputs stable; all 8 results in order, none lost.
//   6. rst_n pulled low with 3 beats in flight -> out_valid=0 at once, no stale results after release.
//      Next beat 0x00FF - 0x000F -> 0x00F0.

Source files
------------

// File: rtl/csel_pkg.sv
// Constants shared by the carry-select adder and subtractor datapaths.
package csel_pkg;

  localparam int CSEL_SEG = 4;

  function automatic int csel_nseg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/csel_seg_sub.sv
// One carry-select subtract segment: both borrow-in cases precomputed, then selected.
module csel_seg_sub #(
  parameter int SEG = csel_pkg::CSEL_SEG
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_bin,
  output logic [SEG-1:0] o_diff,
  output logic           o_bout
);

  logic [SEG:0] w_sum0;
  logic [SEG:0] w_sum1;

  // Two's-complement subtract; a set carry out means no borrow.
  assign w_sum0 = {1'b0, i_a} + {1'b0, ~i_b} + {{SEG{1'b0}}, 1'b1};
  assign w_sum1 = {1'b0, i_a} + {1'b0, ~i_b};

  assign o_diff = i_bin ? w_sum1[SEG-1:0] : w_sum0[SEG-1:0];
  assign o_bout = i_bin ? ~w_sum1[SEG] : ~w_sum0[SEG];

endmodule

// File: rtl/csel_subtractor_pipe.sv
// Pipelined carry-select subtractor, one segment resolved per stage, valid/ready streaming.
// Optional signed-overflow output enabled by defining CSEL_OVF_FLAG_EN.
module csel_subtractor_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = CSEL_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CSEL_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = csel_nseg(WIDTH, SEG);

  logic             w_advance;

  logic             r_vld [NSEG];
  logic             r_brw [NSEG];
  logic [WIDTH-1:0] r_a   [NSEG];
  logic [WIDTH-1:0] r_b   [NSEG];
  logic [WIDTH-1:0] r_d   [NSEG];

  logic             w_vld_in   [NSEG];
  logic             w_brw_in   [NSEG];
  logic [WIDTH-1:0] w_a_in     [NSEG];
  logic [WIDTH-1:0] w_b_in     [NSEG];
  logic [WIDTH-1:0] w_d_in     [NSEG];
  logic [SEG-1:0]   w_seg_d    [NSEG];
  logic             w_seg_bout [NSEG];
  logic [WIDTH-1:0] w_d_next   [NSEG];

  assign w_advance = !r_vld[NSEG-1] | out_ready;
  assign in_ready  = w_advance;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_vld_in[k] = in_valid;
      assign w_brw_in[k] = bin;
      assign w_a_in[k]   = a;
      assign w_b_in[k]   = b;
      assign w_d_in[k]   = '0;
    end else begin : g_next
      assign w_vld_in[k] = r_vld[k-1];
      assign w_brw_in[k] = r_brw[k-1];
      assign w_a_in[k]   = r_a[k-1];
      assign w_b_in[k]   = r_b[k-1];
      assign w_d_in[k]   = r_d[k-1];
    end

    csel_seg_sub #(.SEG(SEG)) u_seg (
      .i_a    (w_a_in[k][k*SEG +: SEG]),
      .i_b    (w_b_in[k][k*SEG +: SEG]),
      .i_bin  (w_brw_in[k]),
      .o_diff (w_seg_d[k]),
      .o_bout (w_seg_bout[k])
    );

    // Splice this segment's result into the already-resolved lower slices.
    assign w_d_next[k] = (w_d_in[k] & ~(WIDTH'({SEG{1'b1}}) << (k*SEG)))
                       | (WIDTH'(w_seg_d[k]) << (k*SEG));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        r_vld[k] <= 1'b0;
        r_brw[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_d[k]   <= '0;
      end
    end else if (w_advance) begin
      for (int k = 0; k < NSEG; k++) begin
        r_vld[k] <= w_vld_in[k];
        r_brw[k] <= w_seg_bout[k];
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_d[k]   <= w_d_next[k];
      end
    end
  end

  assign out_valid = r_vld[NSEG-1];
  assign diff      = r_d[NSEG-1];
  assign bout      = r_brw[NSEG-1];

`ifdef CSEL_OVF_FLAG_EN
  logic r_ovf;
  logic w_ovf_next;

  // Operand sign bits ride along in the top slice of the operand pipeline.
  assign w_ovf_next = (w_a_in[NSEG-1][WIDTH-1] != w_b_in[NSEG-1][WIDTH-1])
                    & (w_d_next[NSEG-1][WIDTH-1] != w_a_in[NSEG-1][WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_advance) begin
      r_ovf <= w_ovf_next;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_csel_subtractor_pipe.sv
// Scoreboard bench for csel_subtractor_pipe (WIDTH=16, SEG=4); checks ovf when CSEL_OVF_FLAG_EN is defined.
module tb_csel_subtractor_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
`ifdef CSEL_OVF_FLAG_EN
  logic        ovf;
`endif

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   stall_arm = 1'b0;
  bit   stall_done = 1'b0;
  int   t5_seen = 0;

  csel_subtractor_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef CSEL_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic summary_and_die(input string why);
    errors++;
    $display("FAIL %s", why);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "aborted");
  endtask

  // Called at negedge+2; returns at negedge+2 after the accepting edge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                      input logic [15:0] ed, input logic eb, input logic eo, input bit lat);
    exp_t e;
    int   waitc;
    waitc    = 0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb_;
    bin      = tbin;
    while (!in_ready) begin
      @(negedge clk); #2;
      waitc++;
      if (waitc > 200) summary_and_die("send_timeout: in_ready never rose");
    end
    e.d = ed; e.bo = eb; e.ov = eo; e.acc = cyc; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk); #2;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    chk("drain_in_budget", 32'(n < 100), 1);
    chk("drain_queue_empty", 32'(sb.size()), 0);
  endtask

  // Monitor: pops and compares on every presented, accepted result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got diff 0x%0h, expected no output", diff);
        end else begin
          e = sb.pop_front();
          chk("diff", 32'(diff), 32'(e.d));
          chk("bout", 32'(bout), 32'(e.bo));
`ifdef CSEL_OVF_FLAG_EN
          chk("ovf", 32'(ovf), 32'(e.ov));
`endif
          if (e.lat) chk("latency", 32'(cyc - e.acc), 4);
          if (stall_arm) t5_seen++;
        end
      end
    end
  end

  // Holds out_ready low for 5 cycles once the 2nd burst result is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (stall_arm && !stall_done && t5_seen == 1 && out_valid) begin
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          #1;
          chk("stall_in_ready", 32'(in_ready), 0);
          chk("stall_out_valid", 32'(out_valid), 1);
          if (sb.size() > 0) begin
            chk("stall_diff", 32'(diff), 32'(sb[0].d));
            chk("stall_bout", 32'(bout), 32'(sb[0].bo));
          end
        end
        @(negedge clk);
        out_ready  = 1'b1;
        stall_done = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    summary_and_die("watchdog: simulation time limit reached");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_bout", 32'(bout), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
`ifdef CSEL_OVF_FLAG_EN
    chk("rst_ovf", 32'(ovf), 0);
`endif
    @(negedge clk); #2;
    rst_n = 1'b1;
    idle(2);

    // Basic subtract with latency check
    send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    drain();

    // Borrow ripples through every segment
    send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    drain();

    // Borrow-in cases
    send(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    send(16'h0003, 16'h0003, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    drain();

    // Signed overflow vectors
    send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    send(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
    drain();

    // Back-to-back burst with downstream stall
    stall_arm = 1'b1;
    t5_seen   = 0;
    send(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    send(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    send(16'hABCD, 16'h1111, 1'b0, 16'h9ABC, 1'b0, 1'b0, 1'b0);
    send(16'h1111, 16'hABCD, 1'b0, 16'h6544, 1'b1, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    send(16'h0F0F, 16'h00F0, 1'b1, 16'h0E1E, 1'b0, 1'b0, 1'b0);
    drain();
    stall_arm = 1'b0;
    chk("stall_happened", 32'(stall_done), 1);
    chk("burst_results_seen", 32'(t5_seen), 8);

    // Reset with beats in flight
    out_ready = 1'b0;
    send(16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0, 1'b0);
    send(16'h2222, 16'h0002, 1'b0, 16'h2220, 1'b0, 1'b0, 1'b0);
    send(16'h3333, 16'h0003, 1'b0, 16'h3330, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("inflight_out_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_diff", 32'(diff), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    sb.delete();
    @(negedge clk); #2;
    @(negedge clk); #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(8);
    send(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
